// File: rtl/mrom_arb_pkg.sv
// Shared types and address-map constants for the program/graphics ROM arbiter.
package mrom_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        CPU,
        VID
    } owner_t;

    localparam logic [15:0] BANK_WIN_LO = 16'hC000;
    localparam logic [15:0] BANK_WIN_HI = 16'hDFFF;
    localparam logic [15:0] IO_BASE     = 16'hE000;
    localparam logic [17:0] BANK_BASE   = 18'h10000;
    localparam logic [7:0]  OPEN_BUS    = 8'hFF;

endpackage

// File: rtl/mrom_addr_map.sv
// Z80 address decode: fixed ROM below 0xC000, banked window at 0xC000-0xDFFF,
// and everything from 0xE000 up is not ROM (answered with open bus).
module mrom_addr_map
    import mrom_arb_pkg::*;
(
    input  logic [15:0] cpu_ad,
    input  logic [2:0]  rombk,
    output logic [17:0] phys_ad,
    output logic        is_rom
);

    always_comb begin
        phys_ad = '0;
        is_rom  = (cpu_ad < IO_BASE);
        if (cpu_ad < BANK_WIN_LO) begin
            phys_ad = {2'b00, cpu_ad};
        end else if (cpu_ad <= BANK_WIN_HI) begin
            phys_ad = BANK_BASE + {2'b00, rombk, cpu_ad[12:0]};
        end
    end

endmodule

// File: rtl/mrom_arbiter.sv
// Single-port ROM arbiter for CPU fetch, video tile fetch and ROM download.
// Define MROM_ARB_RR_EN for round-robin CPU/VID arbitration (default: CPU first).
module mrom_arbiter
    import mrom_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        CPU_REQ,
    input  logic [15:0] CPU_AD,
    input  logic [2:0]  ROMBK,
    output logic        CPU_ACK,
    output logic [7:0]  CPU_DT,
    output logic        CPU_WAIT,
    input  logic        VID_REQ,
    input  logic [17:0] VID_AD,
    output logic        VID_ACK,
    output logic [7:0]  VID_DT,
    input  logic        DL_EN,
    input  logic        DL_WE,
    input  logic [17:0] DL_AD,
    input  logic [7:0]  DL_DT,
    output logic        DL_BUSY,
    output logic        MEM_CS,
    output logic        MEM_WE,
    output logic [17:0] MEM_AD,
    output logic [7:0]  MEM_WD,
    input  logic [7:0]  MEM_DI
);

    arb_state_t  state;
    arb_state_t  state_next;
    owner_t      owner;
    owner_t      grant_owner;
    logic        grant_rd;
    logic        owner_req;
    logic        is_io;
    logic [2:0]  lat_cnt;
    logic        dl_busy;
    logic [17:0] dl_ad_hold;
    logic [7:0]  dl_dt_hold;
    logic [17:0] mem_ad_q;
    logic [7:0]  mem_wd_q;
    logic [7:0]  cpu_dt_q;
    logic [7:0]  vid_dt_q;
    logic [17:0] cpu_phys;
    logic        cpu_is_rom;
`ifdef MROM_ARB_RR_EN
    owner_t      rr_ptr;
`endif

    mrom_addr_map u_addr_map (
        .cpu_ad  (CPU_AD),
        .rombk   (ROMBK),
        .phys_ad (cpu_phys),
        .is_rom  (cpu_is_rom)
    );

    // Reads are held off entirely while a download session is open.
    always_comb begin
        grant_owner = CPU;
        if (VID_REQ && !CPU_REQ) begin
            grant_owner = VID;
        end
`ifdef MROM_ARB_RR_EN
        if (VID_REQ && CPU_REQ && rr_ptr == VID) begin
            grant_owner = VID;
        end
`endif
        grant_rd  = !dl_busy && !DL_EN && (CPU_REQ || VID_REQ);
        owner_req = (owner == CPU) ? CPU_REQ : VID_REQ;
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (dl_busy) begin
                    state_next = WR;
                end else if (grant_rd) begin
                    state_next = (grant_owner == CPU && !cpu_is_rom) ? WAIT : RD;
                end
            end
            WR:      state_next = IDLE;
            RD:      state_next = WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        MEM_CS   = (state == RD) || (state == WR);
        MEM_WE   = (state == WR);
        CPU_ACK  = (state == DONE) && (owner == CPU) && CPU_REQ;
        VID_ACK  = (state == DONE) && (owner == VID) && VID_REQ;
        CPU_WAIT = CPU_REQ && !CPU_ACK;
        DL_BUSY  = dl_busy;
        MEM_AD   = mem_ad_q;
        MEM_WD   = mem_wd_q;
        CPU_DT   = cpu_dt_q;
        VID_DT   = vid_dt_q;
    end

    // Read data only lands in the owner's register if the owner is still asking,
    // so an abandoned request leaves the previous data untouched.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            dl_busy    <= 1'b0;
            dl_ad_hold <= '0;
            dl_dt_hold <= '0;
            mem_ad_q   <= '0;
            mem_wd_q   <= '0;
            cpu_dt_q   <= OPEN_BUS;
            vid_dt_q   <= OPEN_BUS;
            owner      <= CPU;
            is_io      <= 1'b0;
            lat_cnt    <= '0;
`ifdef MROM_ARB_RR_EN
            rr_ptr     <= CPU;
`endif
        end else begin
            if (DL_WE && DL_EN && !dl_busy) begin
                dl_ad_hold <= DL_AD;
                dl_dt_hold <= DL_DT;
                dl_busy    <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (dl_busy) begin
                        mem_ad_q <= dl_ad_hold;
                        mem_wd_q <= dl_dt_hold;
                    end else if (grant_rd) begin
                        owner   <= grant_owner;
                        is_io   <= (grant_owner == CPU) && !cpu_is_rom;
                        lat_cnt <= '0;
                        if (grant_owner == VID) begin
                            mem_ad_q <= VID_AD;
                        end else if (cpu_is_rom) begin
                            mem_ad_q <= cpu_phys;
                        end
`ifdef MROM_ARB_RR_EN
                        rr_ptr <= (grant_owner == CPU) ? VID : CPU;
`endif
                    end
                end
                WR: dl_busy <= 1'b0;
                RD: lat_cnt <= 3'(RD_LAT - 1);
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (owner_req) begin
                            if (owner == CPU) begin
                                cpu_dt_q <= is_io ? OPEN_BUS : MEM_DI;
                            end else begin
                                vid_dt_q <= MEM_DI;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mrom_arbiter.sv
// Scoreboard bench for mrom_arbiter: stimulus pushes expected memory accesses
// and acknowledges; monitors pop and compare whenever the DUT presents them.
module tb_mrom_arbiter;

    localparam int RD_LAT = 2;
    localparam int N_CONT = 20;

    typedef struct packed {
        logic [7:0] data;
        int         ack_cycle;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [17:0] ad;
        logic [7:0]  wd;
    } mem_t;

    logic        MCLK;
    logic        RESET;
    logic        CPU_REQ;
    logic [15:0] CPU_AD;
    logic [2:0]  ROMBK;
    logic        CPU_ACK;
    logic [7:0]  CPU_DT;
    logic        CPU_WAIT;
    logic        VID_REQ;
    logic [17:0] VID_AD;
    logic        VID_ACK;
    logic [7:0]  VID_DT;
    logic        DL_EN;
    logic        DL_WE;
    logic [17:0] DL_AD;
    logic [7:0]  DL_DT;
    logic        DL_BUSY;
    logic        MEM_CS;
    logic        MEM_WE;
    logic [17:0] MEM_AD;
    logic [7:0]  MEM_WD;
    logic [7:0]  MEM_DI;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   cpu_acks = 0;
    int   vid_acks = 0;
    logic [7:0] mem_di = 8'h00;
    logic [7:0] vid_dt_exp = 8'hFF;
    rsp_t cpu_q[$];
    rsp_t vid_q[$];
    mem_t mem_q[$];
    rsp_t rexp;
    mem_t mexp;

    mrom_arbiter #(.RD_LAT(RD_LAT)) dut (
        .MCLK     (MCLK),
        .RESET    (RESET),
        .CPU_REQ  (CPU_REQ),
        .CPU_AD   (CPU_AD),
        .ROMBK    (ROMBK),
        .CPU_ACK  (CPU_ACK),
        .CPU_DT   (CPU_DT),
        .CPU_WAIT (CPU_WAIT),
        .VID_REQ  (VID_REQ),
        .VID_AD   (VID_AD),
        .VID_ACK  (VID_ACK),
        .VID_DT   (VID_DT),
        .DL_EN    (DL_EN),
        .DL_WE    (DL_WE),
        .DL_AD    (DL_AD),
        .DL_DT    (DL_DT),
        .DL_BUSY  (DL_BUSY),
        .MEM_CS   (MEM_CS),
        .MEM_WE   (MEM_WE),
        .MEM_AD   (MEM_AD),
        .MEM_WD   (MEM_WD),
        .MEM_DI   (MEM_DI)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cycle <= cycle + 1;

    // ROM contents: 0x01234 holds 0x5A, everything else is a fixed address hash.
    function automatic logic [7:0] rom_byte(input logic [17:0] ad);
        if (ad == 18'h01234) return 8'h5A;
        return ad[7:0] ^ ad[15:8] ^ {6'd0, ad[17:16]} ^ 8'h3C;
    endfunction

    // Memory model: read data appears the cycle after MEM_CS and is held until the next read.
    always @(posedge MCLK) begin
        if (MEM_CS && !MEM_WE) mem_di <= rom_byte(MEM_AD);
    end
    assign MEM_DI = mem_di;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Monitor: every memory strobe and every acknowledge must match the head of its queue.
    always @(negedge MCLK) begin
        if (MEM_CS) begin
            if (mem_q.size() == 0) begin
                checkOutput("unexpected_mem_cs", 32'd1, 32'd0);
            end else begin
                mexp = mem_q.pop_front();
                checkOutput("mem_we", {31'd0, MEM_WE}, {31'd0, mexp.we});
                checkOutput("mem_ad", {14'd0, MEM_AD}, {14'd0, mexp.ad});
                if (mexp.we) checkOutput("mem_wd", {24'd0, MEM_WD}, {24'd0, mexp.wd});
            end
        end
        if (CPU_ACK) begin
            cpu_acks++;
            if (cpu_q.size() == 0) begin
                checkOutput("unexpected_cpu_ack", 32'd1, 32'd0);
            end else begin
                rexp = cpu_q.pop_front();
                checkOutput("cpu_dt", {24'd0, CPU_DT}, {24'd0, rexp.data});
                checkOutput("cpu_ack_cycle", cycle, rexp.ack_cycle);
            end
        end
        if (VID_ACK) begin
            vid_acks++;
            if (vid_q.size() == 0) begin
                checkOutput("unexpected_vid_ack", 32'd1, 32'd0);
            end else begin
                rexp = vid_q.pop_front();
                vid_dt_exp = rexp.data;
                checkOutput("vid_dt", {24'd0, VID_DT}, {24'd0, rexp.data});
                checkOutput("vid_ack_cycle", cycle, rexp.ack_cycle);
            end
        end
    end

    // One complete read transaction, called just after a rising edge with the arbiter idle.
    task automatic applyStimulus(input bit is_vid, input logic [17:0] ad, input logic [2:0] bk,
                                 input bit rom, input logic [17:0] phys, input logic [7:0] data);
        int start;
        int n;
        rsp_t r;
        mem_t m;
        r.data      = data;
        r.ack_cycle = cycle + (rom ? RD_LAT + 2 : 2);
        m.we = 1'b0;
        m.ad = phys;
        m.wd = 8'h00;
        if (rom) mem_q.push_back(m);
        if (is_vid) begin
            vid_q.push_back(r);
            VID_AD  = ad;
            VID_REQ = 1'b1;
        end else begin
            cpu_q.push_back(r);
            CPU_AD  = ad[15:0];
            ROMBK   = bk;
            CPU_REQ = 1'b1;
        end
        start = is_vid ? vid_acks : cpu_acks;
        @(negedge MCLK);
        if (!is_vid) checkOutput("cpu_wait_pending", {31'd0, CPU_WAIT}, 32'd1);
        n = 0;
        while ((is_vid ? vid_acks : cpu_acks) == start && n < 40) begin
            @(posedge MCLK);
            n++;
        end
        if ((is_vid ? vid_acks : cpu_acks) == start) checkOutput("ack_timeout", 32'd0, 32'd1);
        #1;
        if (is_vid) VID_REQ = 1'b0;
        else CPU_REQ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] t_ad   [6] = '{16'h1234, 16'hC010, 16'hE044, 16'hBFFF, 16'hDFFF, 16'hE000};
        logic [2:0]  t_bk   [6] = '{3'd0, 3'd5, 3'd0, 3'd0, 3'd7, 3'd3};
        logic [17:0] t_phys [6] = '{18'h01234, 18'h1A010, 18'h00000, 18'h0BFFF, 18'h1FFFF, 18'h00000};
        bit          t_rom  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        mem_t m;
        rsp_t r;
        int   c;
        int   s_cpu;
        int   s_vid;
        int   n;

        RESET = 1'b1; CPU_REQ = 1'b0; CPU_AD = '0; ROMBK = '0;
        VID_REQ = 1'b0; VID_AD = '0;
        DL_EN = 1'b0; DL_WE = 1'b0; DL_AD = '0; DL_DT = '0;

        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("rst_cpu_ack", {31'd0, CPU_ACK}, 32'd0);
        checkOutput("rst_vid_ack", {31'd0, VID_ACK}, 32'd0);
        checkOutput("rst_mem_cs", {31'd0, MEM_CS}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        checkOutput("rst_dl_busy", {31'd0, DL_BUSY}, 32'd0);
        checkOutput("rst_mem_ad", {14'd0, MEM_AD}, 32'd0);
        checkOutput("rst_mem_wd", {24'd0, MEM_WD}, 32'd0);
        checkOutput("rst_cpu_dt", {24'd0, CPU_DT}, 32'hFF);
        checkOutput("rst_vid_dt", {24'd0, VID_DT}, 32'hFF);
        @(posedge MCLK); #1;
        RESET = 1'b0;

        $display("[TB] CPU address map and open-bus reads");
        for (int i = 0; i < 6; i++) begin
            @(posedge MCLK); #1;
            applyStimulus(1'b0, {2'b00, t_ad[i]}, t_bk[i], t_rom[i], t_phys[i],
                          t_rom[i] ? rom_byte(t_phys[i]) : 8'hFF);
        end

        $display("[TB] download strobe without DL_EN is ignored");
        @(posedge MCLK); #1;
        DL_AD = 18'h3FFFF; DL_DT = 8'h11; DL_WE = 1'b1;
        @(posedge MCLK); #1;
        DL_WE = 1'b0;
        repeat (3) begin
            @(negedge MCLK);
            checkOutput("dl_busy_no_en", {31'd0, DL_BUSY}, 32'd0);
        end

        $display("[TB] download write holds off a pending CPU read");
        @(posedge MCLK); #1;
        DL_EN = 1'b1; CPU_REQ = 1'b1; CPU_AD = 16'h0042; ROMBK = 3'd0;
        DL_AD = 18'h2ABCD; DL_DT = 8'h77; DL_WE = 1'b1;
        m.we = 1'b1; m.ad = 18'h2ABCD; m.wd = 8'h77;
        mem_q.push_back(m);
        @(posedge MCLK); #1;
        DL_WE = 1'b0;
        @(negedge MCLK);
        checkOutput("dl_busy_set", {31'd0, DL_BUSY}, 32'd1);
        repeat (5) begin
            @(negedge MCLK);
            checkOutput("cpu_wait_dl_en", {31'd0, CPU_WAIT}, 32'd1);
        end
        checkOutput("dl_busy_clear", {31'd0, DL_BUSY}, 32'd0);
        checkOutput("mem_q_after_write", mem_q.size(), 32'd0);
        @(posedge MCLK); #1;
        DL_EN = 1'b0;
        applyStimulus(1'b0, 18'h00042, 3'd0, 1'b1, 18'h00042, rom_byte(18'h00042));

        $display("[TB] CPU and VID requesting continuously");
        @(posedge MCLK); #1;
        c = cycle;
        s_cpu = cpu_acks;
        s_vid = vid_acks;
        for (int i = 0; i < N_CONT; i++) begin
            r.ack_cycle = c + RD_LAT + 2 + i * (RD_LAT + 3);
            m.we = 1'b0;
            m.wd = 8'h00;
`ifdef MROM_ARB_RR_EN
            if (i % 2 == 1) begin
                m.ad = 18'h23456;
                r.data = rom_byte(18'h23456);
                vid_q.push_back(r);
            end else
`endif
            begin
                m.ad = 18'h00100;
                r.data = rom_byte(18'h00100);
                cpu_q.push_back(r);
            end
            mem_q.push_back(m);
        end
        CPU_AD = 16'h0100; ROMBK = 3'd0; CPU_REQ = 1'b1;
        VID_AD = 18'h23456; VID_REQ = 1'b1;
        n = 0;
        while ((cpu_acks - s_cpu) + (vid_acks - s_vid) < N_CONT && n < N_CONT * (RD_LAT + 3) + 20) begin
            @(posedge MCLK);
            n++;
        end
        #1;
        CPU_REQ = 1'b0; VID_REQ = 1'b0;
        checkOutput("cont_total_acks", (cpu_acks - s_cpu) + (vid_acks - s_vid), N_CONT);
`ifdef MROM_ARB_RR_EN
        checkOutput("cont_vid_acks", vid_acks - s_vid, N_CONT / 2);
`else
        checkOutput("cont_vid_acks", vid_acks - s_vid, 32'd0);
`endif

        $display("[TB] reset while a read is waiting for data");
        @(posedge MCLK); #1;
        CPU_AD = 16'h0777; ROMBK = 3'd0; CPU_REQ = 1'b1;
        m.we = 1'b0; m.ad = 18'h00777; m.wd = 8'h00;
        mem_q.push_back(m);
        @(posedge MCLK);
        @(posedge MCLK); #1;
        RESET = 1'b1; CPU_REQ = 1'b0;
        @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("rst_wait_mem_cs", {31'd0, MEM_CS}, 32'd0);
        checkOutput("rst_wait_cpu_ack", {31'd0, CPU_ACK}, 32'd0);
        checkOutput("rst_wait_cpu_dt", {24'd0, CPU_DT}, 32'hFF);
        @(posedge MCLK); #1;
        RESET = 1'b0;
        vid_dt_exp = 8'hFF;
        @(posedge MCLK); #1;
        applyStimulus(1'b0, 18'h00777, 3'd0, 1'b1, 18'h00777, rom_byte(18'h00777));

        $display("[TB] VID request withdrawn while waiting for data");
        @(posedge MCLK); #1;
        VID_AD = 18'h30005; VID_REQ = 1'b1;
        m.we = 1'b0; m.ad = 18'h30005; m.wd = 8'h00;
        mem_q.push_back(m);
        @(posedge MCLK);
        @(posedge MCLK); #1;
        VID_REQ = 1'b0;
        repeat (4) @(negedge MCLK);
        checkOutput("vid_dt_unchanged", {24'd0, VID_DT}, {24'd0, vid_dt_exp});
        @(posedge MCLK); #1;
        applyStimulus(1'b0, 18'h00055, 3'd0, 1'b1, 18'h00055, rom_byte(18'h00055));

        repeat (3) @(posedge MCLK);
        checkOutput("cpu_q_drained", cpu_q.size(), 32'd0);
        checkOutput("vid_q_drained", vid_q.size(), 32'd0);
        checkOutput("mem_q_drained", mem_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
